// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared types and helpers for the multiply/divide unit.
package mdu_hilo_pkg;

    localparam int MDU_DATA_W = 32;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } MDUOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } MDU_STATE_t;

    // Ops that occupy the unit for more than one cycle.
    function automatic logic is_muldiv_op(input MDUOp_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input MDUOp_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Signed variants treat operand MSBs as sign bits.
    function automatic logic is_signed_op(input MDUOp_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_hilo_div_core.sv
// mdu_hilo_div_core: radix-2 restoring divider datapath (div_core).
// Works on unsigned magnitudes; sign handling lives in the parent.
module mdu_hilo_div_core
    import mdu_hilo_pkg::*;
#(
    parameter int W = MDU_DATA_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step_en,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  divisor_q;
    logic [CW-1:0] count_q;
    logic [W:0]    partial;
    logic [W:0]    diff;
    logic [W-1:0]  rem_next;
    logic          quo_bit;

    assign partial = {rem_q, quo_q[W-1]};
    assign diff    = partial - {1'b0, divisor_q};

    // Trial subtraction: keep the difference when it stays non-negative, else restore.
    always_comb begin
        rem_next = partial[W-1:0];
        quo_bit  = 1'b0;
        if (!diff[W]) begin
            rem_next = diff[W-1:0];
            quo_bit  = 1'b1;
        end
    end

    // Load operands on start, then shift one quotient bit in per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            divisor_q <= divisor;
            count_q   <= '0;
        end else if (step_en) begin
            rem_q   <= rem_next;
            quo_q   <= {quo_q[W-2:0], quo_bit};
            count_q <= count_q + 1'b1;
        end
    end

    assign done      = step_en && (count_q == LAST_STEP);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: EXE-stage multiply/divide unit owning the HI/LO registers.
// MULT/MULTU take 3 cycles in EXE, DIV/DIVU take 34; the front end stalls meanwhile.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  MDUOp_t            EXE_MDUOp,
    input  logic              EXE_Valid,
    input  logic [DATA_W-1:0] EXE_OutA,
    input  logic [DATA_W-1:0] EXE_OutB,
    input  logic              MDU_Flush,
    output logic              MDU_Stall,
    output logic [DATA_W-1:0] MDU_Result,
    output logic [DATA_W-1:0] HI_o,
    output logic [DATA_W-1:0] LO_o
);

    MDU_STATE_t state_q, state_d;

    logic                start;
    logic                start_mul;
    logic                start_div;
    logic                stall_raw;
    logic                op_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [2*DATA_W-1:0] mul_a_ext;
    logic [2*DATA_W-1:0] mul_b_ext;
    logic [2*DATA_W-1:0] prod_d;
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   a_raw_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic                div_zero_q;
    logic                is_div_q;
    logic                div_done;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   div_hi;
    logic [DATA_W-1:0]   div_lo;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    assign start     = (state_q == IDLE) && EXE_Valid && !MDU_Flush && is_muldiv_op(EXE_MDUOp);
    assign start_div = start && is_div_op(EXE_MDUOp);
    assign start_mul = start && !is_div_op(EXE_MDUOp);

    assign op_signed = is_signed_op(EXE_MDUOp);
    assign a_neg     = op_signed && EXE_OutA[DATA_W-1];
    assign b_neg     = op_signed && EXE_OutB[DATA_W-1];
    assign a_abs     = a_neg ? -EXE_OutA : EXE_OutA;
    assign b_abs     = b_neg ? -EXE_OutB : EXE_OutB;

    // Sign-extending both operands to full width makes one unsigned multiplier serve both flavours.
    assign mul_a_ext = {{DATA_W{a_neg}}, EXE_OutA};
    assign mul_b_ext = {{DATA_W{b_neg}}, EXE_OutB};
    assign prod_d    = mul_a_ext * mul_b_ext;

    mdu_hilo_div_core #(.W(DATA_W)) u_div_core (
        .clk       (clk),
        .rst_n     (rst),
        .start     (start_div),
        .step_en   (state_q == DIV),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    // Divide-by-zero bypasses sign fixup and returns the raw dividend in HI.
    assign div_lo = div_zero_q ? '1      : (q_neg_q ? -quo : quo);
    assign div_hi = div_zero_q ? a_raw_q : (r_neg_q ? -rem : rem);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush while busy aborts straight back to IDLE.
    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_raw = start;
                if (start) begin
                    state_d = start_div ? DIV : MUL;
                end
            end
            MUL: begin
                stall_raw = 1'b1;
                state_d   = MDU_Flush ? IDLE : DONE;
            end
            DIV: begin
                stall_raw = 1'b1;
                if (MDU_Flush) begin
                    state_d = IDLE;
                end else if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MDU_Stall = rst && stall_raw;

    // Capture the product and the divide bookkeeping when an op starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q     <= '0;
            a_raw_q    <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
        end else if (start) begin
            is_div_q <= start_div;
            if (start_mul) begin
                prod_q <= prod_d;
            end
            if (start_div) begin
                a_raw_q    <= EXE_OutA;
                q_neg_q    <= a_neg ^ b_neg;
                r_neg_q    <= a_neg;
                div_zero_q <= (EXE_OutB == '0);
            end
        end
    end

    // HI/LO update: result commit in DONE, or MTHI/MTLO while idle; flush blocks both.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if ((state_q == DONE) && !MDU_Flush) begin
            hi_d = is_div_q ? div_hi : prod_q[2*DATA_W-1:DATA_W];
            lo_d = is_div_q ? div_lo : prod_q[DATA_W-1:0];
        end else if ((state_q == IDLE) && EXE_Valid && !stall_raw && !MDU_Flush) begin
            if (EXE_MDUOp == OP_MTHI) begin
                hi_d = EXE_OutA;
            end
            if (EXE_MDUOp == OP_MTLO) begin
                lo_d = EXE_OutA;
            end
        end
    end

    // HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // MFHI/MFLO read the registers directly since every write commits in EXE.
    always_comb begin
        MDU_Result = '0;
        if (EXE_MDUOp == OP_MFHI) begin
            MDU_Result = hi_q;
        end else if (EXE_MDUOp == OP_MFLO) begin
            MDU_Result = lo_q;
        end
    end

    assign HI_o = hi_q;
    assign LO_o = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo with directed vectors.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    MDUOp_t      EXE_MDUOp = OP_NOP;
    logic        EXE_Valid = 1'b0;
    logic [31:0] EXE_OutA = '0;
    logic [31:0] EXE_OutB = '0;
    logic        MDU_Flush = 1'b0;
    logic        MDU_Stall;
    logic [31:0] MDU_Result;
    logic [31:0] HI_o;
    logic [31:0] LO_o;

    int check_count = 0;
    int error_count = 0;

    string       exp_name_q[$];
    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    int          exp_stall_q[$];

    mdu_hilo dut (
        .clk        (clk),
        .rst        (rst),
        .EXE_MDUOp  (EXE_MDUOp),
        .EXE_Valid  (EXE_Valid),
        .EXE_OutA   (EXE_OutA),
        .EXE_OutB   (EXE_OutB),
        .MDU_Flush  (MDU_Flush),
        .MDU_Stall  (MDU_Stall),
        .MDU_Result (MDU_Result),
        .HI_o       (HI_o),
        .LO_o       (LO_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the commit edge.
    task automatic applyStimulus(input string name, input MDUOp_t op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input int exp_stall);
        int waited;
        waited = 0;
        exp_name_q.push_back(name);
        exp_hi_q.push_back(exp_hi);
        exp_lo_q.push_back(exp_lo);
        exp_stall_q.push_back(exp_stall);
        EXE_MDUOp = op;
        EXE_OutA  = a;
        EXE_OutB  = b;
        EXE_Valid = 1'b1;
        @(negedge clk);
        while (MDU_Stall && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 100) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL %s_timeout stall still high after %0d cycles", name, waited);
        end
        @(posedge clk);
        #1;
        EXE_Valid = 1'b0;
        EXE_MDUOp = OP_NOP;
    endtask

    // Monitor: a falling stall marks the DONE (or aborted) cycle; compare after the next edge.
    initial begin : monitor
        int run;
        string n;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
            end else if (MDU_Stall) begin
                run++;
            end else if (run > 0) begin
                @(posedge clk);
                #1;
                if (exp_name_q.size() == 0) begin
                    check_count++;
                    error_count++;
                    $display("[TB] FAIL unexpected_completion actual_stall=%0d required=none", run);
                end else begin
                    n = exp_name_q.pop_front();
                    checkOutput({n, "_stall"}, 32'(run), 32'(exp_stall_q.pop_front()));
                    checkOutput({n, "_hi"}, HI_o, exp_hi_q.pop_front());
                    checkOutput({n, "_lo"}, LO_o, exp_lo_q.pop_front());
                end
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        // Reset behaviour, including stall forced low while in reset.
        repeat (2) @(posedge clk);
        #1;
        EXE_Valid = 1'b1;
        EXE_MDUOp = OP_MULT;
        #1;
        checkOutput("reset_stall", {31'b0, MDU_Stall}, 32'h0);
        checkOutput("reset_hi", HI_o, 32'h0);
        checkOutput("reset_lo", LO_o, 32'h0);
        EXE_MDUOp = OP_MFLO;
        #1;
        checkOutput("reset_result", MDU_Result, 32'h0);
        EXE_Valid = 1'b0;
        EXE_MDUOp = OP_NOP;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // MTHI/MTLO then MFHI/MFLO; flushed MTLO must not write.
        EXE_Valid = 1'b1;
        EXE_MDUOp = OP_MTHI;
        EXE_OutA  = 32'h0000_1234;
        @(posedge clk);
        #1;
        EXE_MDUOp = OP_MFHI;
        #1;
        checkOutput("mfhi_after_mthi", MDU_Result, 32'h0000_1234);
        EXE_MDUOp = OP_MTLO;
        EXE_OutA  = 32'h0000_5678;
        @(posedge clk);
        #1;
        EXE_MDUOp = OP_MFLO;
        #1;
        checkOutput("mflo_after_mtlo", MDU_Result, 32'h0000_5678);
        EXE_MDUOp = OP_MTLO;
        EXE_OutA  = 32'h0000_DEAD;
        MDU_Flush = 1'b1;
        @(posedge clk);
        #1;
        MDU_Flush = 1'b0;
        EXE_MDUOp = OP_MFLO;
        #1;
        checkOutput("mtlo_flushed_result", MDU_Result, 32'h0000_5678);
        checkOutput("mtlo_flushed_lo", LO_o, 32'h0000_5678);
        EXE_MDUOp = OP_NOP;
        #1;
        checkOutput("nop_result", MDU_Result, 32'h0);
        EXE_Valid = 1'b0;
        @(posedge clk);
        #1;

        // Multiplies: 2 stall cycles each, issued back to back.
        applyStimulus("mult_neg1x2",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        applyStimulus("multu_maxx2",  OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 2);
        applyStimulus("mult_neg3x5",  OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 2);
        applyStimulus("mult_big",     OP_MULT,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 2);

        // Divides: 33 stall cycles each.
        applyStimulus("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        applyStimulus("div_7_m2",     OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
        applyStimulus("divu_100_7",   OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33);

        // Flush on the 10th DIV cycle: abort, stall drops next cycle, HI/LO keep 2/14.
        exp_name_q.push_back("div_flush");
        exp_hi_q.push_back(32'd2);
        exp_lo_q.push_back(32'd14);
        exp_stall_q.push_back(11);
        EXE_Valid = 1'b1;
        EXE_MDUOp = OP_DIV;
        EXE_OutA  = 32'd1000;
        EXE_OutB  = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        MDU_Flush = 1'b1;
        @(posedge clk);
        #1;
        MDU_Flush = 1'b0;
        EXE_Valid = 1'b0;
        EXE_MDUOp = OP_NOP;
        #1;
        checkOutput("flush_stall_low", {31'b0, MDU_Stall}, 32'h0);
        @(posedge clk);
        #1;

        // Division corner cases.
        applyStimulus("divu_by_zero", OP_DIVU,  32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF, 33);
        applyStimulus("div_m7_by_0",  OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
        applyStimulus("div_overflow", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);

        // Reset mid-divide clears HI/LO at once and drops stall.
        EXE_Valid = 1'b1;
        EXE_MDUOp = OP_DIVU;
        EXE_OutA  = 32'd1000;
        EXE_OutB  = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_hi", HI_o, 32'h0);
        checkOutput("rst_mid_lo", LO_o, 32'h0);
        checkOutput("rst_mid_stall", {31'b0, MDU_Stall}, 32'h0);
        EXE_Valid = 1'b0;
        EXE_MDUOp = OP_NOP;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Unit recovers cleanly after reset.
        applyStimulus("multu_after_rst", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_name_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
